// File: rtl/synth_seq_pkg.sv
// rtl/synth_seq_pkg.sv - shared types and constants for the step sequencer
package synth_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam int SEQ_NOTE_W = 7;
    localparam int REST_BIT   = SEQ_NOTE_W;

    typedef struct packed {
        logic                  rest;
        logic [SEQ_NOTE_W-1:0] note;
    } step_word_t;

    // A tempo of zero would never advance, so it is read as one tick per step.
    localparam logic [7:0] DEFAULT_TEMPO = 8'd1;
    localparam step_word_t REST_WORD     = '{rest: 1'b1, note: '0};

    function automatic logic [7:0] eff_tempo(input logic [7:0] tempo);
        return (tempo == 8'd0) ? DEFAULT_TEMPO : tempo;
    endfunction

endpackage

// File: rtl/seq_tick_prescaler.sv
// rtl/seq_tick_prescaler.sv - clock prescaler producing one-cycle sequencer ticks
module seq_tick_prescaler #(
    parameter int CLK_PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CW   = $clog2(CLK_PRESCALE);
    localparam logic [CW-1:0]   LAST = CW'(CLK_PRESCALE - 1);

    logic [CW-1:0] cnt;

    // Free-running 0..CLK_PRESCALE-1 counter; clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/synth_step_sequencer.sv
// rtl/synth_step_sequencer.sv - 8-step note/gate pattern sequencer for the synth voice
module synth_step_sequencer
    import synth_seq_pkg::*;
#(
    parameter  int CLK_PRESCALE = 1000,
    parameter  int NUM_STEPS    = 8,
    parameter  int NOTE_W       = SEQ_NOTE_W,
    localparam int STEP_W       = $clog2(NUM_STEPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              run,
    input  logic              wr_en,
    input  logic [STEP_W-1:0] wr_addr,
    input  logic [NOTE_W:0]   wr_data,
    input  logic [7:0]        tempo_div,
    input  logic [7:0]        gate_len,
    input  logic [STEP_W-1:0] last_step,
    output logic [NOTE_W-1:0] note,
    output logic              gate,
    output logic [STEP_W-1:0] step_idx,
    output logic              step_strobe,
    output logic              busy
);

    logic [NOTE_W:0]   pattern [NUM_STEPS];

    state_t            state_q, state_d;
    logic [STEP_W-1:0] idx_q, idx_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              gate_q, gate_d;
    logic              strobe_q, strobe_d;
    logic [7:0]        tick_cnt_q, tick_cnt_d;

    logic              load;
    logic [STEP_W-1:0] next_idx;
    logic [STEP_W-1:0] load_idx;
    logic [NOTE_W:0]   load_word;
    logic [8:0]        cnt_inc;
    logic              presc_en;
    logic              presc_clr;
    logic              tick;

    // A last_step lowered beneath the current index wraps on the next advance.
    assign next_idx  = (idx_q >= last_step) ? '0 : idx_q + STEP_W'(1);
    assign load_idx  = (state_q == IDLE) ? '0 : next_idx;
    // Read before this edge's write lands, so a colliding write plays next pass.
    assign load_word = pattern[load_idx];
    assign cnt_inc   = {1'b0, tick_cnt_q} + 9'd1;

    assign presc_en  = ena && (state_q == PLAY);
    assign presc_clr = ena && ((state_q == IDLE) || !run);

    seq_tick_prescaler #(
        .CLK_PRESCALE(CLK_PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    // Pattern store: cleared to rests on reset, writable in any state while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                pattern[i] <= {1'b1, {NOTE_W{1'b0}}};
            end
        end else if (ena && wr_en) begin
            pattern[wr_addr] <= wr_data;
        end
    end

    // State and step datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            note_q     <= '0;
            gate_q     <= 1'b0;
            strobe_q   <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            note_q     <= note_d;
            gate_q     <= gate_d;
            strobe_q   <= strobe_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Next-state: start/stop, tick counting, step advance, gate timer and step load.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        note_d     = note_q;
        gate_d     = gate_q;
        strobe_d   = 1'b0;
        tick_cnt_d = tick_cnt_q;
        load       = 1'b0;

        if (ena) begin
            case (state_q)
                IDLE: begin
                    idx_d      = '0;
                    tick_cnt_d = '0;
                    gate_d     = 1'b0;
                    if (run) begin
                        state_d = PLAY;
                        load    = 1'b1;
                    end
                end
                PLAY: begin
                    if (!run) begin
                        state_d    = IDLE;
                        idx_d      = '0;
                        gate_d     = 1'b0;
                        tick_cnt_d = '0;
                    end else begin
                        if (tick) begin
                            if (cnt_inc >= {1'b0, eff_tempo(tempo_div)}) begin
                                load       = 1'b1;
                                idx_d      = next_idx;
                                tick_cnt_d = '0;
                            end else begin
                                tick_cnt_d = cnt_inc[7:0];
                                if (cnt_inc == {1'b0, gate_len}) begin
                                    gate_d = 1'b0;
                                end
                            end
                        end
                        // Zero gate length still gives a one-cycle pulse on the load cycle.
                        if (!load && (gate_len == 8'd0)) begin
                            gate_d = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (load) begin
                strobe_d = 1'b1;
                if (load_word[NOTE_W]) begin
                    gate_d = 1'b0;
                end else begin
                    note_d = load_word[NOTE_W-1:0];
                    gate_d = 1'b1;
                end
            end
        end
    end

    assign note        = note_q;
    assign gate        = gate_q;
    assign step_idx    = idx_q;
    assign step_strobe = strobe_q && ena;
    assign busy        = (state_q == PLAY);

endmodule

// File: tb/tb_synth_step_sequencer.sv
// tb/tb_synth_step_sequencer.sv - scoreboard bench for synth_step_sequencer
module tb_synth_step_sequencer;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       run = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] tempo_div = 8'd2;
    logic [7:0] gate_len = 8'd1;
    logic [2:0] last_step = '0;
    logic [6:0] note;
    logic       gate;
    logic [2:0] step_idx;
    logic       step_strobe;
    logic       busy;

    synth_step_sequencer #(.CLK_PRESCALE(P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .run        (run),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .tempo_div  (tempo_div),
        .gate_len   (gate_len),
        .last_step  (last_step),
        .note       (note),
        .gate       (gate),
        .step_idx   (step_idx),
        .step_strobe(step_strobe),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int note;
        int gate;
        bit first;
        int interval;
        int prev_gate_hi;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    logic [7:0] mpat [8];
    int m_idx = -1;
    int m_note = 0;
    int m_prev_int = 0;
    int m_prev_hi = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: step order, note/gate per step, step length and gate-high time.
    task automatic push_steps(input int n);
        for (int i = 0; i < n; i++) begin
            int   eff;
            int   idx;
            bit   rest;
            exp_t e;
            eff  = (tempo_div == 0) ? 1 : int'(tempo_div);
            idx  = (m_idx < 0) ? 0 : ((m_idx >= int'(last_step)) ? 0 : m_idx + 1);
            rest = mpat[idx][7];
            if (!rest) m_note = int'(mpat[idx][6:0]);
            e.idx          = idx;
            e.note         = m_note;
            e.gate         = rest ? 0 : 1;
            e.first        = (m_idx < 0);
            e.interval     = m_prev_int;
            e.prev_gate_hi = m_prev_hi;
            q.push_back(e);
            m_idx      = idx;
            m_prev_int = P * eff;
            if (rest)                          m_prev_hi = 0;
            else if (gate_len == 0)            m_prev_hi = 1;
            else if (int'(gate_len) >= eff)    m_prev_hi = P * eff;
            else                               m_prev_hi = P * int'(gate_len);
        end
    endtask

    // Monitor: pops an expectation at each strobe; counts cycles only while enabled.
    int cyc = 0;
    int ghi = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0;
            ghi = 0;
        end else if (ena) begin
            if (step_strobe) begin
                if (q.size() == 0) begin
                    check("strobe_expected", 0, 1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("step_idx", int'(step_idx), e.idx);
                    check("step_note", int'(note), e.note);
                    check("step_gate", int'(gate), e.gate);
                    if (!e.first) begin
                        check("step_interval", cyc, e.interval);
                        check("gate_high_cycles", ghi, e.prev_gate_hi);
                    end
                end
                cyc = 1;
                ghi = gate ? 1 : 0;
            end else if (busy) begin
                cyc++;
                if (gate) ghi++;
            end
        end
    end

    task automatic write_step(input int a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        mpat[a] = d;
    endtask

    task automatic start_run(input int n);
        push_steps(n);
        @(negedge clk);
        run = 1'b1;
    endtask

    task automatic wait_empty();
        int t = 0;
        do begin
            @(negedge clk); #1;
            t++;
        end while (q.size() != 0 && t < 3000);
        if (q.size() != 0) begin
            check("queue_drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic wait_strobe(input int idx);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(step_strobe && int'(step_idx) == idx) && t < 500);
        if (t >= 500) check("wait_strobe_timeout", t, 0);
    endtask

    task automatic stop_run();
        run = 1'b0;
        @(negedge clk);
        check("stop_busy", int'(busy), 0);
        check("stop_gate", int'(gate), 0);
        check("stop_idx", int'(step_idx), 0);
        check("stop_strobe", int'(step_strobe), 0);
        check("stop_note", int'(note), m_note);
        m_idx = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int sbad;
        for (int i = 0; i < 8; i++) mpat[i] = 8'h80;

        repeat (3) @(negedge clk);
        check("reset_note", int'(note), 0);
        check("reset_gate", int'(gate), 0);
        check("reset_idx", int'(step_idx), 0);
        check("reset_strobe", int'(step_strobe), 0);
        check("reset_busy", int'(busy), 0);
        rst_n = 1'b1;

        // Basic playback: 60,62,64,65 then wrap to 60
        write_step(0, 8'd60);
        write_step(1, 8'd62);
        write_step(2, 8'd64);
        write_step(3, 8'd65);
        last_step = 3'd3; tempo_div = 8'd2; gate_len = 8'd1;
        start_run(5);
        wait_empty();
        stop_run();

        // Rest step at index 1
        write_step(1, 8'h80);
        start_run(4);
        wait_empty();
        stop_run();

        // Legato, then shrink last_step while sitting on step 1
        write_step(1, 8'd62);
        gate_len = 8'd5; tempo_div = 8'd2; last_step = 3'd1;
        start_run(2);
        wait_empty();
        last_step = 3'd0;
        push_steps(2);
        wait_empty();
        stop_run();

        // ena freeze mid-step; the write during the freeze must be dropped
        last_step = 3'd3; tempo_div = 8'd4; gate_len = 8'd3;
        push_steps(4);
        @(negedge clk);
        run = 1'b1;
        wait_strobe(0);
        repeat (3) @(negedge clk);
        #1;
        ena = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'd99;
        bad = 0;
        sbad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (step_idx !== 3'd0 || note !== 7'd60 || gate !== 1'b1) bad++;
            if (step_strobe !== 1'b0) sbad++;
        end
        check("freeze_hold_violations", bad, 0);
        check("freeze_strobe_pulses", sbad, 0);
        #1;
        wr_en = 1'b0;
        ena = 1'b1;
        wait_empty();
        stop_run();

        // Write collision on the load edge of step 1
        last_step = 3'd1; tempo_div = 8'd2; gate_len = 8'd1;
        push_steps(2);
        @(negedge clk);
        run = 1'b1;
        wait_strobe(0);
        repeat (P * 2 - 1) @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'd70;
        @(negedge clk);
        wr_en = 1'b0;
        mpat[1] = 8'd70;
        push_steps(2);
        wait_empty();
        stop_run();

        // Randomised rounds
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 8; a++) begin
                logic [7:0] d;
                d = {1'b0, 7'($urandom_range(0, 127))};
                if ($urandom_range(0, 3) == 0) d[7] = 1'b1;
                write_step(a, d);
            end
            last_step = 3'($urandom_range(0, 7));
            tempo_div = 8'($urandom_range(0, 3));
            gate_len  = 8'($urandom_range(0, 4));
            start_run(int'($urandom_range(3, 10)));
            wait_empty();
            stop_run();
        end

        // Asynchronous reset mid-play, then idle
        last_step = 3'd7; tempo_div = 8'd3; gate_len = 8'd1;
        write_step(0, 8'd33);
        start_run(20);
        repeat (15) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_note", int'(note), 0);
        check("async_rst_gate", int'(gate), 0);
        check("async_rst_idx", int'(step_idx), 0);
        check("async_rst_strobe", int'(step_strobe), 0);
        check("async_rst_busy", int'(busy), 0);
        q.delete();
        for (int i = 0; i < 8; i++) mpat[i] = 8'h80;
        m_note = 0;
        m_idx = -1;
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || gate !== 1'b0) bad++;
        end
        check("idle_after_reset_violations", bad, 0);

        // Pattern must read back as rests after reset
        tempo_div = 8'd1; gate_len = 8'd0; last_step = 3'd2;
        start_run(3);
        wait_empty();
        stop_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/synth_step_sequencer.md
Name: synth_step_sequencer

Overview:
- Pattern step sequencer that feeds note/gate commands to the tt_um_synth_GyanepsaaS voice datapath.
- Holds an 8-entry pattern and advances one step every tempo_div ticks. Each step drives a note code and a gate of programmable length.
- Sits between the ui_in/uio_in configuration pins and the synth oscillator/envelope inputs, and is the sole sequencer of the voice.

Parameters:
- CLK_PRESCALE, 1000: clk cycles per sequencer tick; must be >= 2.
- NUM_STEPS, 8: pattern depth; a power of two; STEP_W = log2(NUM_STEPS).
- NOTE_W, 7: note code width; the step word is NOTE_W+1 bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; when low, all state freezes
- run  in  1  level; 1 = play, 0 = stop
- wr_en  in  1  pattern write strobe, one cycle per write
- wr_addr  in  STEP_W  pattern entry to write
- wr_data  in  NOTE_W+1  bit[NOTE_W] = rest flag, bits[NOTE_W-1:0] = note
- tempo_div  in  8  ticks per step; 0 is treated as 1
- gate_len  in  8  ticks the gate stays high within a step
- last_step  in  STEP_W  index of the final step before wrap
- note  out  NOTE_W  current note code to the synth
- gate  out  1  note-on level to the envelope
- step_idx  out  STEP_W  index of the current step
- step_strobe  out  1  one-cycle pulse at every step start
- busy  out  1  high while in PLAY

Behaviour:
- Clock/reset: one clock domain. rst_n is asynchronous assert, synchronous deassert handled upstream.
- Reset values: note=0, gate=0, step_idx=0, step_strobe=0, busy=0, state=IDLE, prescaler=0, tick_cnt=0, all pattern entries=rest (MSB=1, note=0).
- Pattern writes: accepted on any cycle with ena=1 and wr_en=1, in both states. The entry updates at the clock edge.
- Write/load collision: if a write targets the same entry being loaded that cycle, the load uses the old contents.
- State IDLE: outputs hold their reset values. When run=1 is sampled, go to PLAY, load step 0 in the same edge, assert step_strobe for one cycle, and clear prescaler and tick_cnt. The first strobe appears one cycle after run is sampled high.
- State PLAY, ticks: the prescaler counts 0..CLK_PRESCALE-1 and emits a one-cycle tick at the wrap. tick_cnt increments on each tick.
- State PLAY, step advance: when a tick brings tick_cnt to max(tempo_div,1):
  - next index = 0 if step_idx >= last_step, else step_idx+1;
  - tick_cnt resets to 0;
  - the new entry loads and step_strobe pulses.
- Step load:
  - rest flag set: gate=0 and note holds its previous value;
  - otherwise: note = entry note and gate=1 in the same cycle as step_strobe.
- Gate off: gate drops on the tick where tick_cnt reaches gate_len.
  - gate_len=0: the gate still pulses high for the load cycle only.
  - gate_len >= tempo_div: the gate stays high across the step boundary (legato) unless the next step is a rest.
- Changing last_step below step_idx mid-play: the next advance wraps to 0. tempo_div and gate_len are sampled live, with no shadowing.
- run=0 in PLAY: on the next edge go to IDLE with gate=0, step_idx=0, busy=0, counters cleared. note holds. No strobe is issued.
- ena=0: every register holds, including the prescaler. Writes are ignored and step_strobe is forced low. Resuming continues exactly where it stopped.
- Reset mid-play: immediate return to the reset values above. The pattern is cleared to rests.

Decomposition:
- Package synth_seq_pkg holds:
  - state enum {IDLE, PLAY};
  - REST_BIT index;
  - step_word_t struct {rest, note};
  - DEFAULT_TEMPO and REST_WORD constants.
- Sub-module seq_tick_prescaler (CLK_PRESCALE counter with enable and clear, producing the tick pulse).
- The pattern store, step FSM and gate timer stay in the top module.

Test Plan (bench overrides CLK_PRESCALE=4):
- Reset then idle: assert rst_n=0 mid-run -> all outputs 0 within the same cycle, with no clock edge needed. After release, busy=0 and gate=0 for 50 cycles with run=0.
- Basic playback:
  - stimulus: write steps 0..3 = notes 60, 62, 64, 65; last_step=3, tempo_div=2, gate_len=1; raise run;
  - expected: step_strobe every 8 clks; note sequence 60, 62, 64, 65, 60;
  - expected: gate high for 4 clks of each 8.
- Rest step: write step 1 = 0x80 -> during step 1, gate=0 and note stays 60. No gate rise occurs until step 2 loads 64.
- Legato and wrap:
  - stimulus: gate_len=5, tempo_div=2, last_step=1;
  - expected: gate continuously high; step_idx toggles 0,1,0;
  - then drop last_step to 0 while at step 1 -> next step is 0.
- Stop/ena freeze:
  - stimulus: drop ena for 20 clks mid-step;
  - expected: step_idx, note and gate unchanged, no strobe, step timing resumes exactly;
  - then run=0 -> next cycle gate=0, step_idx=0, busy=0.
- Write collision: wr_en to the current next step on the exact cycle it loads -> the old note plays this pass and the new note plays on the next pass.
